// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg -- shared constants and types for the button-entry
// sequence detector.
//   MODE_OVERLAP / MODE_NONOVERLAP : encodings of the Mode input
//   *_DEF                          : default parameter values
//   bit_evt_t                      : decoded button event for one cycle
package seq_detect_pkg;

    localparam logic MODE_OVERLAP    = 1'b0;
    localparam logic MODE_NONOVERLAP = 1'b1;

    localparam int PAT_W_DEF  = 4;
    localparam int HIST_W_DEF = 8;
    localparam int CNT_W_DEF  = 8;

    typedef struct packed {
        logic valid;    // exactly one button rose: a bit is entered
        logic bit_val;  // entered bit (P1 -> 1, P0 -> 0)
        logic err;      // both buttons rose together
    } bit_evt_t;

endpackage

// File: rtl/edge_pulse.sv
// edge_pulse -- one-register rising-edge detector.
//   clk  : clock
//   rst  : asynchronous active-high reset, clears the sample register
//   d    : level input, synchronous to clk
//   rise : high while d is 1 and its previous sample was 0
// Because reset clears the sample, a level still high after reset
// reads as a fresh rise on the first edge.
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) d_q <= 1'b0;
        else     d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/seq_detect_n.sv
// seq_detect_n -- serial pattern detector fed by two push buttons.
//   Clk, Reset : clock, asynchronous active-high reset
//   P0, P1     : debounced button levels entering a 0 / a 1 on each rise
//   B          : target pattern, B[PAT_W-1] entered first
//   Mode       : MODE_OVERLAP or MODE_NONOVERLAP
//   Clear      : synchronous clear of history, fill and count
//   Hist       : last HIST_W accepted bits, newest at LSB
//   Match      : one-cycle pulse per detected pattern
//   Count      : saturating match count
//   Err        : one-cycle pulse when both buttons rise together
module seq_detect_n
    import seq_detect_pkg::*;
#(
    parameter int PAT_W  = PAT_W_DEF,
    parameter int HIST_W = HIST_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              P0,
    input  logic              P1,
    input  logic [PAT_W-1:0]  B,
    input  logic              Mode,
    input  logic              Clear,
    output logic [HIST_W-1:0] Hist,
    output logic              Match,
    output logic [CNT_W-1:0]  Count,
    output logic              Err
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [1:0] btn;
    logic [1:0] rise;

    assign btn = {P1, P0};

    for (genvar i = 0; i < 2; i++) begin : g_edge
        edge_pulse u_edge (
            .clk  (Clk),
            .rst  (Reset),
            .d    (btn[i]),
            .rise (rise[i])
        );
    end

    bit_evt_t evt;

    always_comb begin
        evt         = '0;
        evt.valid   = rise[0] ^ rise[1];
        evt.bit_val = rise[1];
        evt.err     = rise[0] & rise[1];
    end

    logic [HIST_W-1:0] hist_q;
    logic [FILL_W-1:0] fill_q;
    logic [CNT_W-1:0]  count_q;
    logic              match_q;
    logic              err_q;

    // Candidate window and fill as they would be after this bit; the match
    // decision uses B and Mode live in the event cycle.
    logic [PAT_W-1:0]  new_pat;
    logic [FILL_W-1:0] fill_inc;
    logic              hit;

    assign new_pat  = {hist_q[PAT_W-2:0], evt.bit_val};
    assign fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    assign hit      = evt.valid && (fill_inc == FILL_FULL) && (new_pat == B);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            match_q <= 1'b0;
            // Err is reported even when Clear wins the cycle.
            err_q   <= evt.err;
            if (Clear) begin
                hist_q  <= '0;
                fill_q  <= '0;
                count_q <= '0;
            end else if (evt.valid) begin
                hist_q  <= {hist_q[HIST_W-2:0], evt.bit_val};
                // Non-overlapping mode restarts the fill so the next match
                // needs a full fresh pattern; Hist is kept for display.
                fill_q  <= (hit && Mode == MODE_NONOVERLAP) ? '0 : fill_inc;
                match_q <= hit;
                if (hit && count_q != '1)
                    count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign Hist  = hist_q;
    assign Match = match_q;
    assign Count = count_q;
    assign Err   = err_q;

endmodule

// File: tb/tb_seq_detect_n.sv
module tb_seq_detect_n;
    import seq_detect_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       P0, P1, Mode, Clear;
    logic [3:0] B;
    logic [7:0] Hist, Hist_s;
    logic       Match, Match_s, Err, Err_s;
    logic [7:0] Count;
    logic [1:0] Count_s;

    always #5 Clk = ~Clk;

    seq_detect_n #(.PAT_W(4), .HIST_W(8), .CNT_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .P0(P0), .P1(P1), .B(B), .Mode(Mode),
        .Clear(Clear), .Hist(Hist), .Match(Match), .Count(Count), .Err(Err));

    // Narrow counter copy sharing all inputs, for saturation.
    seq_detect_n #(.PAT_W(4), .HIST_W(8), .CNT_W(2)) dut_s (
        .Clk(Clk), .Reset(Reset), .P0(P0), .P1(P1), .B(B), .Mode(Mode),
        .Clear(Clear), .Hist(Hist_s), .Match(Match_s), .Count(Count_s), .Err(Err_s));

    typedef struct {
        logic [7:0] hist;
        logic [7:0] cnt;
    } exp_t;

    exp_t       qm[$];
    logic [1:0] qs[$];
    bit         qe[$];
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One button press: expectation queued first, rise accepted at the next
    // posedge, Match visible at the following negedge.
    task automatic press(input bit b, input bit m, input logic [7:0] h, input int c);
        if (m) begin
            qm.push_back('{h, 8'(c)});
            qs.push_back((c > 3) ? 2'd3 : 2'(c));
        end
        @(negedge Clk);
        if (b) P1 = 1'b1; else P0 = 1'b1;
        @(negedge Clk);
        P0 = 1'b0; P1 = 1'b0;
        check("hist", 32'(Hist), 32'(h));
        check("count", 32'(Count), 32'(c));
        @(negedge Clk);
    endtask

    task automatic do_clear();
        @(negedge Clk); Clear = 1'b1;
        @(negedge Clk); Clear = 1'b0;
    endtask

    initial begin
        exp_t e;
        logic [1:0] es;
        Reset = 1'b1; P0 = 1'b0; P1 = 1'b0; Mode = MODE_OVERLAP; Clear = 1'b0; B = 4'b0000;

        fork
            forever begin
                @(negedge Clk);
                if (Match) begin
                    if (qm.size() == 0) begin
                        check("match_unexpected", 32'(Hist), 32'hFFFF_FFFF);
                    end else begin
                        e = qm.pop_front();
                        check("match_hist", 32'(Hist), 32'(e.hist));
                        check("match_count", 32'(Count), 32'(e.cnt));
                    end
                end
                if (Match_s) begin
                    if (qs.size() == 0) begin
                        check("match_s_unexpected", 32'(Count_s), 32'hFFFF_FFFF);
                    end else begin
                        es = qs.pop_front();
                        check("match_s_count", 32'(Count_s), 32'(es));
                    end
                end
                if (Err) begin
                    if (qe.size() == 0) check("err_unexpected", 32'(Err), 32'd0);
                    else void'(qe.pop_front());
                end
            end
        join_none

        #3;
        check("rst_hist", 32'(Hist), 0);
        check("rst_count", 32'(Count), 0);
        check("rst_match", 32'(Match), 0);
        @(negedge Clk); Reset = 1'b0;

        // B=0110 overlapping
        B = 4'b0110; Mode = MODE_OVERLAP;
        press(1,0,8'h01,0); press(0,0,8'h02,0); press(1,0,8'h05,0); press(1,0,8'h0B,0);
        press(0,1,8'h16,1); press(1,0,8'h2D,1); press(1,0,8'h5B,1); press(0,1,8'hB6,2);

        // B=0011: never seen
        do_clear(); B = 4'b0011;
        press(1,0,8'h01,0); press(0,0,8'h02,0); press(1,0,8'h05,0); press(1,0,8'h0B,0);
        press(0,0,8'h16,0); press(1,0,8'h2D,0); press(1,0,8'h5B,0); press(0,0,8'hB6,0);

        // B=1011 overlapping
        do_clear(); B = 4'b1011;
        press(1,0,8'h01,0); press(0,0,8'h02,0); press(1,0,8'h05,0); press(1,1,8'h0B,1);
        press(0,0,8'h16,1); press(1,0,8'h2D,1); press(1,1,8'h5B,2); press(0,0,8'hB6,2);

        // B=1011 non-overlapping
        do_clear(); Mode = MODE_NONOVERLAP;
        press(1,0,8'h01,0); press(0,0,8'h02,0); press(1,0,8'h05,0); press(1,1,8'h0B,1);
        press(0,0,8'h16,1); press(1,0,8'h2D,1); press(1,0,8'h5B,1); press(0,0,8'hB6,1);

        // B=1010, both modes
        do_clear(); B = 4'b1010; Mode = MODE_OVERLAP;
        press(1,0,8'h01,0); press(0,0,8'h02,0); press(1,0,8'h05,0);
        press(0,1,8'h0A,1); press(1,0,8'h15,1); press(0,1,8'h2A,2);
        do_clear(); Mode = MODE_NONOVERLAP;
        press(1,0,8'h01,0); press(0,0,8'h02,0); press(1,0,8'h05,0);
        press(0,1,8'h0A,1); press(1,0,8'h15,1); press(0,0,8'h2A,1);

        // both buttons together: Err only, state unchanged
        qe.push_back(1'b1);
        @(negedge Clk); P0 = 1'b1; P1 = 1'b1;
        @(negedge Clk); P0 = 1'b0; P1 = 1'b0;
        check("err_hist", 32'(Hist), 32'h2A);
        check("err_count", 32'(Count), 1);
        @(negedge Clk);
        check("err_once", 32'(Err), 0);

        // Clear wins over a P1 rise
        @(negedge Clk); Clear = 1'b1; P1 = 1'b1;
        @(negedge Clk); Clear = 1'b0; P1 = 1'b0;
        check("clr_hist", 32'(Hist), 0);
        check("clr_count", 32'(Count), 0);
        @(negedge Clk);

        // held button enters one bit only
        @(negedge Clk); P1 = 1'b1;
        repeat (4) @(negedge Clk);
        P1 = 1'b0;
        @(negedge Clk);
        check("held_hist", 32'(Hist), 32'h01);

        // async reset mid-cycle, then fill must restart from zero
        do_clear(); B = 4'b0000; Mode = MODE_OVERLAP;
        press(1,0,8'h01,0); press(0,0,8'h02,0); press(1,0,8'h05,0);
        @(posedge Clk); #2 Reset = 1'b1;
        #1;
        check("arst_hist", 32'(Hist), 0);
        check("arst_count", 32'(Count), 0);
        check("arst_match", 32'(Match), 0);
        check("arst_err", 32'(Err), 0);
        @(negedge Clk); Reset = 1'b0;
        press(0,0,8'h00,0); press(0,0,8'h00,0); press(0,0,8'h00,0); press(0,1,8'h00,1);

        // button held through reset release counts as a new rise
        @(negedge Clk); Reset = 1'b1; P1 = 1'b1;
        @(negedge Clk); Reset = 1'b0;
        @(negedge Clk);
        check("rst_held_hist", 32'(Hist), 32'h01);
        P1 = 1'b0;
        @(negedge Clk);

        // five overlapping matches; narrow counter saturates at 3
        do_clear(); B = 4'b1111; Mode = MODE_OVERLAP;
        press(1,0,8'h01,0); press(1,0,8'h03,0); press(1,0,8'h07,0); press(1,1,8'h0F,1);
        press(1,1,8'h1F,2); press(1,1,8'h3F,3); press(1,1,8'h7F,4); press(1,1,8'hFF,5);
        check("sat_count_s", 32'(Count_s), 3);

        repeat (3) @(negedge Clk);
        check("pending_match", 32'(qm.size()), 0);
        check("pending_match_s", 32'(qs.size()), 0);
        check("pending_err", 32'(qe.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
